// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter where the owner keeps the grant until
// it drops its request, with a hold-cycle limit that forces rotation.
module rr_hold_arbiter #(
  parameter int NUM_REQUESTERS  = 8,
  parameter int INDEX_WIDTH     = 3,
  parameter int MAX_HOLD_CYCLES = 16
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic [NUM_REQUESTERS-1:0] request_in,
  input  logic                      resource_ready_in,
  output logic [NUM_REQUESTERS-1:0] grant_out,
  output logic [INDEX_WIDTH-1:0]    grant_index_out,
  output logic                      grant_valid_out,
  output logic                      preempt_out
);

  localparam int HW =
    (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;

  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD_CYCLES);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX =
    INDEX_WIDTH'(NUM_REQUESTERS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    PREEMPT = 2'd2
  } state_t;

  state_t                    state;
  logic [INDEX_WIDTH-1:0]    priority_ptr;
  logic [HW-1:0]             hold_cnt;

  logic [INDEX_WIDTH-1:0]    next_ptr;
  logic [INDEX_WIDTH-1:0]    sel_ptr;
  logic [INDEX_WIDTH-1:0]    win_hi;
  logic [INDEX_WIDTH-1:0]    win_lo;
  logic [INDEX_WIDTH-1:0]    winner;
  logic [NUM_REQUESTERS-1:0] win_oh;
  logic                      hi_hit;
  logic                      any_req;
  logic                      owner_req;
  logic                      preempt_due;
  logic                      hold_sat;

  assign any_req   = |request_in;
  assign owner_req = |(request_in & grant_out);
  assign hold_sat  = &hold_cnt;

  assign preempt_due =
    (MAX_HOLD_CYCLES != 0) && (hold_cnt == HOLD_LIM);

  // pointer just past the current owner, wrapped at the last requester
  assign next_ptr = (grant_index_out == LAST_IDX)
                  ? '0
                  : grant_index_out + 1'b1;

  // a release searches from just past the owner, idle uses the pointer
  assign sel_ptr = (state == GRANTED) ? next_ptr : priority_ptr;

  // two find-first-one searches: at/above sel_ptr, and over everything
  always_comb begin
    hi_hit = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      if (request_in[i]) begin
        win_lo = INDEX_WIDTH'(i);
        if (INDEX_WIDTH'(i) >= sel_ptr) begin
          hi_hit = 1'b1;
          win_hi = INDEX_WIDTH'(i);
        end
      end
    end
  end

  assign winner = hi_hit ? win_hi : win_lo;

  // one-hot form of the winning index
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      win_oh[i] = (winner == INDEX_WIDTH'(i));
    end
  end

  // ownership FSM with registered grant outputs
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state           <= IDLE;
      priority_ptr    <= '0;
      hold_cnt        <= '0;
      grant_out       <= '0;
      grant_index_out <= '0;
      grant_valid_out <= 1'b0;
      preempt_out     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          preempt_out <= 1'b0;
          if (resource_ready_in && any_req) begin
            state           <= GRANTED;
            hold_cnt        <= HW'(1);
            grant_out       <= win_oh;
            grant_index_out <= winner;
            grant_valid_out <= 1'b1;
          end else begin
            hold_cnt        <= '0;
            grant_out       <= '0;
            grant_index_out <= '0;
            grant_valid_out <= 1'b0;
          end
        end
        GRANTED: begin
          if (!owner_req) begin
            priority_ptr <= next_ptr;
            if (resource_ready_in && any_req) begin
              hold_cnt        <= HW'(1);
              grant_out       <= win_oh;
              grant_index_out <= winner;
              grant_valid_out <= 1'b1;
            end else begin
              state           <= IDLE;
              hold_cnt        <= '0;
              grant_out       <= '0;
              grant_index_out <= '0;
              grant_valid_out <= 1'b0;
            end
          end else if (preempt_due) begin
            state           <= PREEMPT;
            priority_ptr    <= next_ptr;
            hold_cnt        <= '0;
            grant_out       <= '0;
            grant_index_out <= '0;
            grant_valid_out <= 1'b0;
            preempt_out     <= 1'b1;
          end else if (!hold_sat) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        PREEMPT: begin
          state       <= IDLE;
          preempt_out <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          hold_cnt        <= '0;
          grant_out       <= '0;
          grant_index_out <= '0;
          grant_valid_out <= 1'b0;
          preempt_out     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: two arbiter instances (8 and 5 requesters)
// compared every cycle against a rotating-search ownership model.
module tb_rr_hold_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rdy;

  logic [7:0] grant_a;
  logic [2:0] idx_a;
  logic       valid_a;
  logic       pre_a;

  logic [4:0] grant_b;
  logic [2:0] idx_b;
  logic       valid_b;
  logic       pre_b;

  int total = 0;
  int bad   = 0;

  int m_own  [2];
  int m_ptr  [2];
  int m_held [2];
  bit m_pre  [2];
  int m_n    [2] = '{8, 5};
  int m_max  [2] = '{16, 0};

  always #5 clk = ~clk;

  rr_hold_arbiter #(
    .NUM_REQUESTERS (8),
    .INDEX_WIDTH    (3),
    .MAX_HOLD_CYCLES(16)
  ) u_dut_a (
    .clk_in           (clk),
    .reset_n_in       (rst_n),
    .request_in       (req),
    .resource_ready_in(rdy),
    .grant_out        (grant_a),
    .grant_index_out  (idx_a),
    .grant_valid_out  (valid_a),
    .preempt_out      (pre_a)
  );

  rr_hold_arbiter #(
    .NUM_REQUESTERS (5),
    .INDEX_WIDTH    (3),
    .MAX_HOLD_CYCLES(0)
  ) u_dut_b (
    .clk_in           (clk),
    .reset_n_in       (rst_n),
    .request_in       (req[4:0]),
    .resource_ready_in(rdy),
    .grant_out        (grant_b),
    .grant_index_out  (idx_b),
    .grant_valid_out  (valid_b),
    .preempt_out      (pre_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s observed=0x%0h expected=0x%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r,
                              input int sel,
                              input int n);
    int j;
    for (int k = 0; k < n; k++) begin
      j = (sel + k) % n;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i]  = -1;
      m_ptr[i]  = 0;
      m_held[i] = 0;
      m_pre[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input int i,
                            input logic [7:0] r_in,
                            input logic rd);
    logic [7:0] r;
    int n;
    n = m_n[i];
    r = r_in & 8'((1 << n) - 1);
    if (m_pre[i]) begin
      m_pre[i] = 1'b0;
      m_own[i] = -1;
    end else if (m_own[i] < 0) begin
      if (rd && r != 0) begin
        m_own[i]  = pick(r, m_ptr[i], n);
        m_held[i] = 1;
      end
    end else if (!r[m_own[i]]) begin
      m_ptr[i] = (m_own[i] + 1) % n;
      if (rd && r != 0) begin
        m_own[i]  = pick(r, m_ptr[i], n);
        m_held[i] = 1;
      end else begin
        m_own[i] = -1;
      end
    end else if (m_max[i] != 0 && m_held[i] == m_max[i]) begin
      m_ptr[i] = (m_own[i] + 1) % n;
      m_own[i] = -1;
      m_pre[i] = 1'b1;
    end else begin
      m_held[i]++;
    end
  endtask

  function automatic logic [31:0] exp_grant(input int i);
    return (m_own[i] < 0) ? 32'd0 : (32'd1 << m_own[i]);
  endfunction

  function automatic logic [31:0] exp_index(input int i);
    return (m_own[i] < 0) ? 32'd0 : 32'(m_own[i]);
  endfunction

  task automatic compare_all();
    check("a_grant", 32'(grant_a), exp_grant(0));
    check("a_index", 32'(idx_a), exp_index(0));
    check("a_valid", 32'(valid_a), 32'(m_own[0] >= 0));
    check("a_preempt", 32'(pre_a), 32'(m_pre[0]));
    check("b_grant", 32'(grant_b), exp_grant(1));
    check("b_index", 32'(idx_b), exp_index(1));
    check("b_valid", 32'(valid_b), 32'(m_own[1] >= 0));
    check("b_preempt", 32'(pre_b), 32'(m_pre[1]));
  endtask

  task automatic tick(input logic [7:0] r, input logic rd);
    @(negedge clk);
    compare_all();
    req = r;
    rdy = rd;
    model_step(0, r, rd);
    model_step(1, r, rd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    rdy   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    rdy   = 1'b0;
    do_reset();

    // single request, one-cycle latency
    tick(8'h04, 1'b1);
    tick(8'h04, 1'b1);
    check("t1_grant", 32'(grant_a), 32'h04);
    check("t1_index", 32'(idx_a), 32'd2);
    check("t1_valid", 32'(valid_a), 32'd1);

    // release hands over with no bubble
    do_reset();
    tick(8'h81, 1'b1);
    tick(8'h80, 1'b1);
    check("t2_first", 32'(grant_a), 32'h01);
    tick(8'h80, 1'b1);
    check("t2_grant", 32'(grant_a), 32'h80);
    check("t2_index", 32'(idx_a), 32'd7);

    // hold limit with a competitor
    do_reset();
    tick(8'h03, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      tick(8'h03, 1'b1);
      check("t3_hold", 32'(idx_a), 32'd0);
      check("t3_hold_v", 32'(valid_a), 32'd1);
    end
    tick(8'h03, 1'b1);
    check("t3_preempt", 32'(pre_a), 32'd1);
    check("t3_pre_v", 32'(valid_a), 32'd0);
    tick(8'h03, 1'b1);
    tick(8'h03, 1'b1);
    check("t3_next", 32'(grant_a), 32'h02);

    // hold limit with a lone requester
    do_reset();
    tick(8'h01, 1'b1);
    for (int j = 1; j <= 16; j++) tick(8'h01, 1'b1);
    tick(8'h01, 1'b1);
    check("t3b_preempt", 32'(pre_a), 32'd1);
    tick(8'h01, 1'b1);
    tick(8'h01, 1'b1);
    check("t3b_regrant", 32'(grant_a), 32'h01);

    // resource not ready blocks granting
    do_reset();
    for (int j = 0; j < 6; j++) begin
      tick(8'h0F, 1'b0);
      check("t4_blocked", 32'(valid_a), 32'd0);
    end
    tick(8'h0F, 1'b1);
    tick(8'h0F, 1'b1);
    check("t4_grant", 32'(grant_a), 32'h01);

    // asynchronous reset mid-grant
    do_reset();
    tick(8'h20, 1'b1);
    tick(8'h20, 1'b1);
    check("t5_owner", 32'(idx_a), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_g", 32'(grant_a), 32'd0);
    check("t5_async_v", 32'(valid_a), 32'd0);
    check("t5_async_i", 32'(idx_a), 32'd0);
    do_reset();
    tick(8'hA0, 1'b1);
    tick(8'hA0, 1'b1);
    check("t5_after", 32'(idx_a), 32'd5);

    // full rotation across eight requesters
    do_reset();
    tick(8'hFF, 1'b1);
    for (int j = 0; j < 18; j++) begin
      int e;
      e = (j / 2) % 8;
      tick((j % 2 == 1) ? (8'hFF & ~(8'h01 << e)) : 8'hFF, 1'b1);
      check("t6_valid", 32'(valid_a), 32'd1);
      check("t6_order", 32'(idx_a), 32'(e));
    end

    // rotation wrap with five requesters
    do_reset();
    tick(8'h1F, 1'b1);
    for (int j = 0; j < 14; j++) begin
      int e;
      e = (j / 2) % 5;
      tick((j % 2 == 1) ? (8'h1F & ~(8'h01 << e)) : 8'h1F, 1'b1);
      check("t6b_valid", 32'(valid_b), 32'd1);
      check("t6b_order", 32'(idx_b), 32'(e));
    end

    // randomized traffic with sticky owners and occasional resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] r;
      logic       rd;
      r = 8'($urandom);
      if ($urandom_range(0, 1) == 1) r = r & 8'($urandom);
      if (m_own[0] >= 0) begin
        r[m_own[0]] = ($urandom_range(0, 15) != 0);
      end
      rd = ($urandom_range(0, 3) != 0);
      tick(r, rd);
      if (c % 1000 == 999) begin
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        do_reset();
      end
    end
    tick(8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
